// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART register bridge.
// Frame command bytes, reply bytes and the responder FSM states.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6
    } state_e;

endpackage

// File: rtl/uart_reg_bridge.sv
// Decodes 'W'/'R' register frames from the UART receiver, performs one bus
// access and hands a single reply byte back to the UART transmitter.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 8680
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    output logic              frame_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              is_rd_q, is_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;
        cnt_d     = '0;
        ferr_d    = 1'b0;
        // Bytes arriving outside IDLE/GET_* fall through untouched (dropped).
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_rd_d = (rx_data == CMD_RD);
                        state_d = ST_GET_ADDR;
                    end else begin
                        tx_data_d = RSP_ERR;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    state_d = is_rd_q ? ST_BUS_RD : ST_GET_DATA;
                end else if (cnt_q == CNT_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_data;
                    state_d = ST_BUS_WR;
                end else if (cnt_q == CNT_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BUS_WR: begin
                tx_data_d = RSP_ACK;
                state_d   = ST_SEND;
            end
            ST_BUS_RD: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                tx_data_d = bus_rdata;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            ferr_q    <= ferr_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = (state_q == ST_SEND);
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = (state_q == ST_BUS_WR);
    assign bus_re    = (state_q == ST_BUS_RD);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: write/read/unknown frames, timeout,
// byte-at-expiry, stalled reply with dropped bytes, and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_reg_bridge;

    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic          bus_we;
    logic          bus_re;
    logic [7:0]    bus_rdata;
    logic          frame_err;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int ferr_cnt = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    uart_reg_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .frame_err (frame_err)
    );

    // Register slave: read data appears the cycle after bus_re.
    always @(posedge clk) begin
        if (bus_re) bus_rdata <= mem[bus_addr];
        if (bus_we) mem[bus_addr] <= bus_wdata;
    end

    always @(negedge clk) begin
        if (bus_we)    we_cnt++;
        if (bus_re)    re_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for a reply, then let tx_ready (held high) accept it.
    task automatic wait_reply(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, tx_valid, 1);
        check({tag, "_data"}, tx_data, exp);
        @(posedge clk);
        #1;
        $display("TXN %s reply=0x%02h", tag, tx_data);
    endtask

    initial begin
        int found, stray, bad, we0, re0, f0;
        n_rst    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_re", bus_re, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Write 0x57,0x03,0xA5 with exact latency.
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
        @(negedge clk);
        check("wr_we_t1", bus_we, 1);
        check("wr_addr", bus_addr, 3);
        check("wr_wdata", bus_wdata, 8'hA5);
        check("wr_txv_t1", tx_valid, 0);
        @(negedge clk);
        check("wr_we_t2", bus_we, 0);
        check("wr_txv_t2", tx_valid, 1);
        check("wr_txd_t2", tx_data, 8'h4B);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wr_accepted", tx_valid, 0);
        check("wr_we_count", we_cnt, 1);
        $display("TXN write addr=3 data=0xa5");

        // Back-to-back write to addr 2.
        send_byte(8'h57); send_byte(8'h02); send_byte(8'h5C);
        wait_reply("wr2", 8'h4B);

        // Read 0x52,0x03 with exact latency.
        re0 = re_cnt;
        send_byte(8'h52); send_byte(8'h03);
        @(negedge clk);
        check("rd_re_t1", bus_re, 1);
        check("rd_addr", bus_addr, 3);
        @(negedge clk);
        check("rd_re_t2", bus_re, 0);
        check("rd_txv_t2", tx_valid, 0);
        @(negedge clk);
        check("rd_txv_t3", tx_valid, 1);
        check("rd_txd_t3", tx_data, 8'hA5);
        check("rd_re_count", re_cnt - re0, 1);
        @(posedge clk);
        #1;
        $display("TXN read addr=3 data=0x%02h", tx_data);

        // Unknown command.
        we0 = we_cnt; re0 = re_cnt;
        send_byte(8'h41);
        @(negedge clk);
        check("unk_txv", tx_valid, 1);
        check("unk_txd", tx_data, 8'h3F);
        check("unk_no_we", we_cnt - we0, 0);
        check("unk_no_re", re_cnt - re0, 0);
        @(posedge clk);
        #1;
        $display("TXN unknown byte=0x41");

        // Timeout between addr and data.
        we0 = we_cnt; f0 = ferr_cnt;
        send_byte(8'h57); send_byte(8'h02);
        found = 0; stray = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tx_valid || bus_we) stray++;
            if (frame_err && found == 0) found = i;
        end
        check("to_cycle", found, TO + 1);
        check("to_pulses", ferr_cnt - f0, 1);
        check("to_no_activity", stray, 0);
        check("to_no_we", we_cnt - we0, 0);
        $display("TXN timeout frame_err at +%0d", found);
        send_byte(8'h52); send_byte(8'h02);
        wait_reply("rd_after_to", 8'h5C);

        // Bytes arriving exactly at expiry win over the timeout.
        we0 = we_cnt; f0 = ferr_cnt;
        send_byte(8'h57);
        idle(TO - 1);
        send_byte(8'h04);
        idle(TO - 1);
        send_byte(8'h3C);
        @(negedge clk);
        check("edge_we", bus_we, 1);
        check("edge_addr", bus_addr, 4);
        check("edge_wdata", bus_wdata, 8'h3C);
        check("edge_no_ferr", ferr_cnt - f0, 0);
        wait_reply("edge_wr", 8'h4B);

        // Stalled reply; bytes during SEND are dropped.
        we0 = we_cnt; re0 = re_cnt;
        tx_ready = 1'b0;
        send_byte(8'h41);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h3F)) bad++;
            if (i == 10) begin rx_data = 8'h57; rx_valid = 1'b1; end
            if (i == 11) rx_data = 8'h52;
            if (i == 12) begin rx_valid = 1'b0; rx_data = 8'h00; end
        end
        check("stall_stable", bad, 0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_accepted", tx_valid, 0);
        check("stall_no_bus", (we_cnt - we0) + (re_cnt - re0), 0);
        $display("TXN stalled reply 0x3f held 100 cycles");
        send_byte(8'h52); send_byte(8'h04);
        wait_reply("rd_after_stall", 8'h3C);

        // Reset between addr and data of a write.
        we0 = we_cnt;
        send_byte(8'h57); send_byte(8'h06);
        #2;
        n_rst = 1'b0;
        #1;
        check("mrst_addr", bus_addr, 0);
        check("mrst_wdata", bus_wdata, 0);
        check("mrst_txv", tx_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send_byte(8'hAA);
        @(negedge clk);
        check("mrst_unk_txd", tx_data, 8'h3F);
        check("mrst_no_we", we_cnt - we0, 0);
        @(posedge clk);
        #1;
        $display("TXN reset mid-frame");
        send_byte(8'h52); send_byte(8'h03);
        wait_reply("rd_after_rst", 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
